seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative restoring radix-2 divider; the inverse of the multiplier datapath built from the partial-product reduction stages.
- Takes an unsigned dividend and divisor through a start/done handshake.
- Produces quotient and remainder one bit per clock.
- Sits beside the multiplier in the ALU execute path; shares the operand buses and the result mux.

Parameters:
- WIDTH, 8, operand width in bits; dividend, divisor, quotient and remainder are all WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; operands sampled when accepted
- a  input  WIDTH  dividend
- b  input  WIDTH  divisor
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results become valid
- q  output  WIDTH  quotient
- r  output  WIDTH  remainder
- dz  output  1  divide-by-zero flag for the last operation

Behaviour:
- Single clock; synchronous active-high reset.
- Reset values:
  - state=IDLE
  - busy=0, done=0, dz=0
  - q=0, r=0
  - counter=0
  - internal partial remainder and quotient registers = 0
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 latches a and b.
  - If b==0: go to FIN and set dz=1, q=all ones, r=a.
  - Otherwise: clear the partial remainder P (WIDTH+1 bits), load shift register Q=a, load counter=WIDTH, go to RUN, set busy=1.
- RUN, one iteration per cycle:
  - Shift {P,Q} left by one.
  - T = P_shifted - {0,b}.
  - If T is non-negative (T[WIDTH]==0): P=T and Q[0]=1. Otherwise keep P_shifted and set Q[0]=0.
  - Decrement the counter. When the counter reaches 1 during an iteration, go to FIN after that iteration.
- FIN:
  - Drive q=Q and r=P[WIDTH-1:0].
  - done=1 for exactly this cycle; busy=0.
  - Next state IDLE.
- Latency: start accepted at cycle 0 -> done at cycle WIDTH+1. With b==0, done at cycle 1.
- q, r and dz hold their values until the next accepted start. On acceptance of a new start, dz is cleared unless the new b==0.
- Start is ignored while busy=1. A start in the FIN cycle is also ignored; the earliest accepted start is the cycle after done.
- Reset during RUN or FIN:
  - Aborts the operation.
  - The next cycle shows all reset values.
  - No done pulse is produced.
- Width rule: the subtraction is WIDTH+1 bits wide, so no overflow is possible. The quotient is exact (floor); the remainder is always < b.
- Edge cases:
  - a < b gives q=0, r=a.
  - a==b gives q=1, r=0.
  - a=all ones, b=1 gives q=all ones, r=0.

Optional Feature:
- Macro SEQ_DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - At accept, latch sign flags and absolute values, then run the unsigned core.
  - In FIN: negate q if the operand signs differ; give r the sign of a (truncating division).
  - b==0 gives q=all ones, r=a, dz=1.
  - Most-negative / -1 gives q=most-negative, r=0 (wraps); no flag.
  - Latency unchanged.
- Undefined: unsigned only; no sign logic is synthesized.

Decomposition:
- Shared package (alu_pkg) holds:
  - the divider state enum (IDLE/RUN/FIN), 2-bit encoding
  - the default WIDTH constant, shared with the multiplier
- Natural sub-module div_step (combinational):
  - Inputs: P, the incoming Q MSB and b.
  - Outputs: the next P and the quotient bit.
- seq_divider holds the state machine, counter and registers.

Test Plan (WIDTH=8):
- Basic: reset, then start with a=100, b=7.
  - done pulses exactly 9 cycles after start, with q=14, r=2, dz=0.
  - busy is high for 8 cycles.
- Divide by zero: a=55, b=0.
  - Next cycle: done=1, dz=1, q=255, r=55.
  - busy is never asserted.
- Boundaries:
  - a=5, b=9 gives q=0, r=5.
  - a=255, b=1 gives q=255, r=0.
  - a=200, b=200 gives q=1, r=0.
- Handshake:
  - Pulse start again with a=9, b=3 at cycle 3 of a busy operation (a=100, b=7). It is ignored; results are q=14, r=2.
  - Start asserted the cycle after done is accepted; that operation produces q=3, r=0.
- Reset mid-operation: assert reset at cycle 4 of a run.
  - All outputs are 0 the next cycle; no done pulse.
  - A subsequent a=81, b=9 gives q=9, r=0.
- SEQ_DIV_SIGNED_EN build:
  - -100/7 gives q=-14, r=-2.
  - 100/-7 gives q=-14, r=2.
  - -128/-1 gives q=-128, r=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Types and constants shared by the ALU execute-path blocks (multiplier and divider).
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract b,
// keep the difference when it is non-negative.
module div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH:0]   p,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   p_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] trial;

    // One spare bit so the whole partial remainder takes part in the subtraction;
    // the sign of the trial result sits in the top bit.
    assign trial  = {p, q_msb} - {2'b00, b};
    assign q_bit  = ~trial[WIDTH+1];
    assign p_next = q_bit ? trial[WIDTH:0] : {p[WIDTH-1:0], q_msb};

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring radix-2 divider, one quotient bit per clock, start/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    div_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH:0]   p_reg, p_next;
    logic [WIDTH-1:0] qs_reg, qs_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic             dz_reg, dz_next;

    logic [WIDTH:0]   step_p;
    logic             step_bit;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] q_raw, r_raw, q_fin, r_fin;

`ifdef SEQ_DIV_SIGNED_EN
    logic sa_reg, sa_next;
    logic sb_reg, sb_next;

    always_comb begin
        a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
        // Quotient negative when signs differ; remainder follows the dividend.
        q_fin = (sa_reg ^ sb_reg) ? (~q_raw + WIDTH'(1)) : q_raw;
        r_fin = sa_reg ? (~r_raw + WIDTH'(1)) : r_raw;
    end
`else
    always_comb begin
        a_mag = a;
        b_mag = b;
        q_fin = q_raw;
        r_fin = r_raw;
    end
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .p      (p_reg),
        .q_msb  (qs_reg[WIDTH-1]),
        .b      (b_reg),
        .p_next (step_p),
        .q_bit  (step_bit)
    );

    assign q_raw = {qs_reg[WIDTH-2:0], step_bit};
    assign r_raw = step_p[WIDTH-1:0];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        p_next     = p_reg;
        qs_next    = qs_reg;
        b_next     = b_reg;
        q_next     = q_reg;
        r_next     = r_reg;
        dz_next    = dz_reg;
`ifdef SEQ_DIV_SIGNED_EN
        sa_next    = sa_reg;
        sb_next    = sb_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    b_next  = b_mag;
                    dz_next = (b == '0);
`ifdef SEQ_DIV_SIGNED_EN
                    sa_next = a[WIDTH-1];
                    sb_next = b[WIDTH-1];
`endif
                    if (b == '0) begin
                        q_next     = '1;
                        r_next     = a;
                        state_next = FIN;
                    end else begin
                        p_next     = '0;
                        qs_next    = a_mag;
                        cnt_next   = CNT_W'(WIDTH);
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                p_next   = step_p;
                qs_next  = q_raw;
                cnt_next = cnt_reg - CNT_W'(1);
                // Results are registered on the last iteration so they are valid in FIN.
                if (cnt_reg == CNT_W'(1)) begin
                    q_next     = q_fin;
                    r_next     = r_fin;
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            p_reg     <= '0;
            qs_reg    <= '0;
            b_reg     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            dz_reg    <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            sa_reg    <= 1'b0;
            sb_reg    <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            p_reg     <= p_next;
            qs_reg    <= qs_next;
            b_reg     <= b_next;
            q_reg     <= q_next;
            r_reg     <= r_next;
            dz_reg    <= dz_next;
`ifdef SEQ_DIV_SIGNED_EN
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
`endif
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == FIN);
    assign q    = q_reg;
    assign r    = r_reg;
    assign dz   = dz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed handshake/boundary cases plus random
// operands compared against plain arithmetic division.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, dz;
    logic [W-1:0] q, r;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dz    (dz)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void ref_div(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                    output logic [W-1:0] eq, output logic [W-1:0] er,
                                    output logic edz);
        int sa, sb;
        edz = (bb == 0);
        if (bb == 0) begin
            eq = '1;
            er = aa;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            sa = int'($signed(aa));
            sb = int'($signed(bb));
`else
            sa = int'(aa);
            sb = int'(bb);
`endif
            eq = W'(sa / sb);
            er = W'(sa % sb);
        end
    endfunction

    // Runs one operation; returns in the done cycle. poke_cyc injects a stray start.
    task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input int poke_cyc);
        logic [W-1:0] eq, er;
        logic         edz;
        int           cyc, busy_n;
        bit           seen;
        ref_div(aa, bb, eq, er, edz);
        @(posedge clk); #1;
        check("done_pulse_len", done, 0);
        start = 1'b1; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; busy_n = 0; seen = 0;
        while (!seen && cyc <= 40) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy) busy_n++;
                if (cyc == poke_cyc) begin
                    start = 1'b1; a = 9; b = 3;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("latency", cyc, (bb == 0) ? 1 : W + 1);
        check("busy_cycles", busy_n, (bb == 0) ? 0 : W);
        check("busy_in_fin", busy, 0);
        check("q", q, eq);
        check("r", r, er);
        check("dz", dz, edz);
        $display("txn a=%0d b=%0d q=%0d r=%0d dz=%0d lat=%0d", aa, bb, q, r, dz, cyc);
    endtask

    initial begin
        int done_cnt;
        logic [W-1:0] ra, rb;
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_dz", dz, 0);
        reset = 1'b0;

        run_op(8'd100, 8'd7, 0);
        check("basic_q", q, 14);
        check("basic_r", r, 2);
        run_op(8'd55, 8'd0, 0);
        check("dz_q", q, 255);
        check("dz_r", r, 55);
        check("dz_flag", dz, 1);
        run_op(8'd5, 8'd9, 0);
        check("small_q", q, 0);
        check("dz_cleared", dz, 0);
        run_op(8'd255, 8'd1, 0);
        check("max_q", q, 255);
        run_op(8'd200, 8'd200, 0);
        check("eq_q", q, 1);
        check("eq_r", r, 0);

        // Stray start at cycle 3 of a busy operation must not disturb it.
        run_op(8'd100, 8'd7, 3);
        check("ign_busy_q", q, 14);
        check("ign_busy_r", r, 2);

        // Start presented in the FIN cycle is ignored.
        start = 1'b1; a = 9; b = 3;
        @(posedge clk); #1;
        start = 1'b0;
        check("fin_start_done", done, 0);
        @(posedge clk); #1;
        check("fin_start_busy", busy, 0);

        run_op(8'd9, 8'd3, 0);
        check("b2b_q", q, 3);

        // Reset at cycle 4 of a run.
        @(posedge clk); #1;
        start = 1'b1; a = 100; b = 7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_q", q, 0);
        check("mid_rst_r", r, 0);
        check("mid_rst_dz", dz, 0);
        done_cnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("mid_rst_no_done", done_cnt, 0);
        run_op(8'd81, 8'd9, 0);
        check("after_rst_q", q, 9);

`ifdef SEQ_DIV_SIGNED_EN
        run_op(8'h9C, 8'd7, 0);
        check("s_nq", q, 8'hF2);
        check("s_nr", r, 8'hFE);
        run_op(8'd100, 8'hF9, 0);
        check("s_dq", q, 8'hF2);
        check("s_dr", r, 8'd2);
        run_op(8'h80, 8'hFF, 0);
        check("s_wrap_q", q, 8'h80);
        check("s_wrap_r", r, 0);
        check("s_wrap_dz", dz, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(0, 255));
            run_op(ra, rb, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
